// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, FSM encoding and parity helper for the
//               parametrised UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int CLK_HZ               = 50_000_000;
    localparam int BAUD_DEFAULT         = 115_200;
    // 50 MHz / 115200 truncates to 434 clocks per bit.
    localparam int CLKS_PER_BIT_DEFAULT = CLK_HZ / BAUD_DEFAULT;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Even parity is the XOR of the payload; odd parity inverts it.
    // Narrow payloads are zero-extended, which does not change the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input int par_mode);
        return (^data) ^ (par_mode == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Single-clock synchronous FIFO. Storage is flop based, so the
//               head entry is readable in the same cycle it is popped.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // Pointer and occupancy next-state; a simultaneous push and pop holds count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param
// Description : Parametrised UART transmitter with input FIFO. Frames are
//               start, DATA_BITS (LSB first), optional parity, STOP_BITS stop,
//               sent back-to-back while the FIFO holds data.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          fpga_clk1,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;

    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 bit_done;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (fpga_clk1),
        .rst       (rst),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Held low during reset so nothing is accepted while the FIFO is flushed.
    assign in_ready = !fifo_full && !rst;
    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign bit_done = (baud_q == BAUD_LAST);

    // Frame sequencing: next state, bit counters, shift register and tx level.
    always_comb begin
        state_d    = state_q;
        baud_d     = bit_done ? '0 : baud_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_START;
                    shift_d  = fifo_rd_data;
                    parity_d = parity_bit(8'(fifo_rd_data), PARITY);
                    tx_d     = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == BIT_LAST) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = ST_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (stop_idx_q == STOP_LAST) begin
                        // Chain straight into the next frame when data waits.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            state_d  = ST_START;
                            shift_d  = fifo_rd_data;
                            parity_d = parity_bit(8'(fifo_rd_data), PARITY);
                            tx_d     = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State register; reset aborts any frame and returns the line to idle high.
    always_ff @(posedge fpga_clk1) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with an input FIFO, configurable frame format (data bits, parity, stop bits) and a valid/ready byte interface. It is the next-generation serial output path for the display controller's host link. It replaces the fixed-format transmitter and is driven from the 50 MHz board clock. Upstream logic pushes bytes without pacing; the block serialises them back-to-back onto `tx`.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (434 gives 115200 baud at 50 MHz); must be ≥ 2.
- `DATA_BITS`, 8: payload bits per frame, 5..8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: entries, power of two, ≥ 2.

Ports:
- `fpga_clk1`  in  1: system clock; everything is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_data`  in  DATA_BITS: byte to transmit.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: FIFO can accept; a transfer happens on an edge where `in_valid` and `in_ready` are both 1.
- `tx`  out  1: serial line, idle high, registered.
- `busy`  out  1: a frame is in progress, or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Frame, sent LSB first: start (0), `DATA_BITS` data bits, optional parity, `STOP_BITS` stop bits (1).
- Parity bit:
  - even: XOR of the data bits;
  - odd: inverse of that XOR.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. On that edge the FSM pops the FIFO, loads the shift register and drives `tx` to 0.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → PARITY (or STOP when `PARITY`=0) after `DATA_BITS` bit periods. The bit index counts 0..DATA_BITS-1.
  - PARITY → STOP after one bit period.
  - STOP ends after `STOP_BITS` bit periods. On that final edge the FSM goes to START, popping again, if the FIFO is non-empty; otherwise it goes to IDLE. There is no idle gap between queued frames.
- Baud counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, cleared on every bit transition.
- `in_ready` = !full. A push when full is impossible by construction.
- A push and a pop on the same edge leave `fifo_count` unchanged. A push into an empty FIFO is visible to the FSM on the next edge (no bypass).
- Reset values:
  - `tx`=1, `busy`=0, `fifo_count`=0, FSM=IDLE;
  - `in_ready`=0 while `rst` is high, 1 on the first cycle after.
- Reset mid-frame aborts the frame and flushes the FIFO; `tx` is 1 after the reset edge.
- `in_data` bits above `DATA_BITS` do not exist; the width is exact.

## Timing
- Handshake at edge N into an empty, idle block: pop at edge N+1, `tx` falls after edge N+1.
- Every bit, start and stop included, lasts exactly `CLKS_PER_BIT` cycles.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- `busy` deasserts on the edge where STOP ends with the FIFO empty. `tx` stays 1 from then on.
- `fifo_count` updates on the edge after the push or pop.

## Structure
- `uart_pkg`:
  - parity constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - FSM state encoding;
  - `CLK_HZ`=50_000_000 and the default `CLKS_PER_BIT`.
- Sub-module `uart_tx_fifo`: synchronous single-clock FIFO with parameters `WIDTH`/`DEPTH`, ports push/pop/full/empty/count, and registered read data available in the pop cycle.
- Top level: FSM, baud counter, shift register, parity generator.

## Test plan
- Defaults with `CLKS_PER_BIT`=4, push 0xA5: `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. Falling edge one cycle after the handshake. `busy` low after 40 cycles.
- `PARITY`=2, `STOP_BITS`=2, push 0x07: parity bit 1, two stop bits, frame length 48 cycles. Repeat with `PARITY`=1: parity bit 0.
- `DATA_BITS`=5, `PARITY`=0, push 0x13: 7-bit frame 0,1,1,0,0,1,1 (28 cycles).
- Push 17 bytes continuously with `FIFO_DEPTH`=16:
  - `in_ready` drops when `fifo_count`=16;
  - all 17 bytes appear back-to-back with no idle cycles between frames;
  - order is preserved.
- Assert `rst` mid-DATA with 3 bytes queued: on the next edge `tx`=1, `fifo_count`=0, `busy`=0. No further frames appear.
- Push and pop on the same edge with `fifo_count`=5: count stays 5 and no data is lost (scoreboard check).
